// File: rtl/halt_dump_unit_if.sv
// Dump-unit bus bundle: memory read port, register read port and the output word stream.
// master = dump unit side, slave = memory/register file plus consumer side.
interface halt_dump_unit_if #(
  parameter int DW     = 16,
  parameter int MEM_AW = 8,
  parameter int REG_AW = 4
);
  logic              mem_rd_en;
  logic [MEM_AW-1:0] mem_rd_addr;
  logic [DW-1:0]     mem_rd_data;
  logic              reg_rd_en;
  logic [REG_AW-1:0] reg_rd_idx;
  logic [DW-1:0]     reg_rd_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [DW-1:0]     dump_data;
  logic              dump_is_reg;
  logic [MEM_AW-1:0] dump_index;

  modport master (
    output mem_rd_en, mem_rd_addr, input mem_rd_data,
    output reg_rd_en, reg_rd_idx, input reg_rd_data,
    output dump_valid, input dump_ready,
    output dump_data, dump_is_reg, dump_index
  );

  modport slave (
    input mem_rd_en, mem_rd_addr, output mem_rd_data,
    input reg_rd_en, reg_rd_idx, output reg_rd_data,
    input dump_valid, output dump_ready,
    input dump_data, dump_is_reg, dump_index
  );
endinterface

// File: rtl/halt_dump_unit.sv
// Post-halt dump: on a do_halt 1->0 edge, streams memory words then registers out, one word per 3+ cycles.
// First read strobe 1 cycle after start detect, first valid 3 cycles after; holds a word indefinitely while dump_ready=0.
module halt_dump_unit #(
  parameter int DW        = 16,
  parameter int MEM_AW    = 8,
  parameter int MEM_WORDS = 16,
  parameter int REG_AW    = 4,
  parameter int REG_COUNT = 16
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              do_halt,
  halt_dump_unit_if.master  bus,
  output logic              busy,
  output logic              dump_done
);

  localparam logic [MEM_AW-1:0] MEM_LAST = MEM_AW'(MEM_WORDS - 1);
  localparam logic [MEM_AW-1:0] REG_LAST = MEM_AW'(REG_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MEM_RD, S_MEM_WAIT, S_MEM_OUT,
    S_REG_RD, S_REG_WAIT, S_REG_OUT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              halt_q, halt_d;
  logic [MEM_AW-1:0] idx_q, idx_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [MEM_AW-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic              reg_rd_en_q, reg_rd_en_d;
  logic [REG_AW-1:0] reg_rd_idx_q, reg_rd_idx_d;
  logic              dump_valid_q, dump_valid_d;
  logic [DW-1:0]     dump_data_q, dump_data_d;
  logic              dump_is_reg_q, dump_is_reg_d;
  logic [MEM_AW-1:0] dump_index_q, dump_index_d;
  logic              busy_q, busy_d;
  logic              dump_done_q, dump_done_d;

  always_comb begin
    state_d       = state_q;
    halt_d        = do_halt;
    idx_d         = idx_q;
    dump_valid_d  = dump_valid_q;
    dump_data_d   = dump_data_q;
    dump_is_reg_d = dump_is_reg_q;
    dump_index_d  = dump_index_q;
    case (state_q)
      S_IDLE: begin
        if (halt_q && !do_halt) begin
          state_d = S_MEM_RD;
          idx_d   = '0;
        end
      end
      S_MEM_RD:   state_d = S_MEM_WAIT;
      S_MEM_WAIT: begin
        state_d       = S_MEM_OUT;
        dump_valid_d  = 1'b1;
        dump_data_d   = bus.mem_rd_data;
        dump_is_reg_d = 1'b0;
        dump_index_d  = idx_q;
      end
      S_MEM_OUT: begin
        // Compare before incrementing so a full 2**MEM_AW sweep never wraps.
        if (bus.dump_ready) begin
          dump_valid_d = 1'b0;
          if (idx_q == MEM_LAST) begin
            state_d = S_REG_RD;
            idx_d   = '0;
          end else begin
            state_d = S_MEM_RD;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      S_REG_RD:   state_d = S_REG_WAIT;
      S_REG_WAIT: begin
        state_d       = S_REG_OUT;
        dump_valid_d  = 1'b1;
        dump_data_d   = bus.reg_rd_data;
        dump_is_reg_d = 1'b1;
        dump_index_d  = idx_q;
      end
      S_REG_OUT: begin
        if (bus.dump_ready) begin
          dump_valid_d = 1'b0;
          if (idx_q == REG_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_REG_RD;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered off the next state so they line up with the state they describe.
    mem_rd_en_d   = (state_d == S_MEM_RD);
    reg_rd_en_d   = (state_d == S_REG_RD);
    mem_rd_addr_d = mem_rd_en_d ? idx_d : mem_rd_addr_q;
    reg_rd_idx_d  = reg_rd_en_d ? idx_d[REG_AW-1:0] : reg_rd_idx_q;
    dump_done_d   = (state_d == S_DONE);
    busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q       <= S_IDLE;
      halt_q        <= 1'b0;
      idx_q         <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      reg_rd_en_q   <= 1'b0;
      reg_rd_idx_q  <= '0;
      dump_valid_q  <= 1'b0;
      dump_data_q   <= '0;
      dump_is_reg_q <= 1'b0;
      dump_index_q  <= '0;
      busy_q        <= 1'b0;
      dump_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      halt_q        <= halt_d;
      idx_q         <= idx_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      reg_rd_en_q   <= reg_rd_en_d;
      reg_rd_idx_q  <= reg_rd_idx_d;
      dump_valid_q  <= dump_valid_d;
      dump_data_q   <= dump_data_d;
      dump_is_reg_q <= dump_is_reg_d;
      dump_index_q  <= dump_index_d;
      busy_q        <= busy_d;
      dump_done_q   <= dump_done_d;
    end
  end

  assign bus.mem_rd_en   = mem_rd_en_q;
  assign bus.mem_rd_addr = mem_rd_addr_q;
  assign bus.reg_rd_en   = reg_rd_en_q;
  assign bus.reg_rd_idx  = reg_rd_idx_q;
  assign bus.dump_valid  = dump_valid_q;
  assign bus.dump_data   = dump_data_q;
  assign bus.dump_is_reg = dump_is_reg_q;
  assign bus.dump_index  = dump_index_q;
  assign busy            = busy_q;
  assign dump_done       = dump_done_q;

endmodule

// File: tb/tb_halt_dump_unit.sv
// Bench for halt_dump_unit: small (16+16) instance for ordering/backpressure/abort, large (256+1) instance for the no-wrap sweep.
module tb_halt_dump_unit;

  typedef struct packed {
    logic        is_reg;
    logic [7:0]  idx;
    logic [15:0] data;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic do_halt = 1'b0;
  logic do_halt_b = 1'b0;
  logic busy_s, done_s, busy_b, done_b;

  halt_dump_unit_if #(.DW(16), .MEM_AW(8), .REG_AW(4)) sbus ();
  halt_dump_unit_if #(.DW(16), .MEM_AW(8), .REG_AW(4)) bbus ();

  halt_dump_unit #(.DW(16), .MEM_AW(8), .MEM_WORDS(16), .REG_AW(4), .REG_COUNT(16)) u_dut (
    .CLK(clk), .rst(rst), .do_halt(do_halt), .bus(sbus), .busy(busy_s), .dump_done(done_s)
  );

  halt_dump_unit #(.DW(16), .MEM_AW(8), .MEM_WORDS(256), .REG_AW(4), .REG_COUNT(1)) u_big (
    .CLK(clk), .rst(rst), .do_halt(do_halt_b), .bus(bbus), .busy(busy_b), .dump_done(done_b)
  );

  always #5 clk = ~clk;

  logic [15:0] mem_s [256];
  logic [15:0] regs_s [16];
  logic [15:0] mem_b [256];
  localparam logic [15:0] REG_B0 = 16'h5A5A;

  // Read data is only meaningful the cycle after a strobe; poison it otherwise.
  always @(posedge clk) begin
    sbus.mem_rd_data <= sbus.mem_rd_en ? mem_s[sbus.mem_rd_addr] : 16'hDEAD;
    sbus.reg_rd_data <= sbus.reg_rd_en ? regs_s[sbus.reg_rd_idx] : 16'hBAD0;
    bbus.mem_rd_data <= bbus.mem_rd_en ? mem_b[bbus.mem_rd_addr] : 16'hDEAD;
    bbus.reg_rd_data <= (bbus.reg_rd_en && bbus.reg_rd_idx == 4'd0) ? REG_B0 : 16'hBAD0;
  end

  int mem_strb_s = 0, reg_strb_s = 0, strobe_viol = 0;
  always @(negedge clk) begin
    if (sbus.mem_rd_en) mem_strb_s++;
    if (sbus.reg_rd_en) reg_strb_s++;
    if ((sbus.mem_rd_en && sbus.reg_rd_en) ||
        ((sbus.mem_rd_en || sbus.reg_rd_en) && (sbus.dump_valid || !busy_s))) strobe_viol++;
    if ((bbus.mem_rd_en && bbus.reg_rd_en) ||
        ((bbus.mem_rd_en || bbus.reg_rd_en) && (bbus.dump_valid || !busy_b))) strobe_viol++;
  end

  int tests = 0, fails = 0;
  word_t exp_q[$];
  word_t obs_q[$];
  int n_acc, n_done, done_c, last_acc_c, first_rd_c, first_vld_c, hold_bad, stall_cnt, stall_strobes;
  int rd_mem_n, rd_reg_n;
  bit timed_out, rst_hit, done_busy, idle_after;
  logic [41:0] rst_vec;

  task automatic fill_small_exp;
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(word_t'({1'b0, 8'(i), 16'(i * 3)}));
    for (int i = 0; i < 16; i++)
      exp_q.push_back(word_t'({1'b1, 8'(i), (i == 7) ? 16'd7 : (i == 10) ? 16'd624 : 16'd0}));
  endtask

  // mode 0: always ready, 1: random ready, 2: stall word 3 for 10 cycles.
  task automatic run_small(input int mode, input int edge_at, input int rst_at_reg);
    int stall, edge_st, m0, r0;
    word_t w;
    obs_q.delete();
    n_acc = 0; n_done = 0; done_c = -1; last_acc_c = -1; first_rd_c = -1; first_vld_c = -1;
    hold_bad = 0; stall_strobes = 0; timed_out = 0; rst_hit = 0; done_busy = 1; idle_after = 0;
    rst_vec = '1; stall = 0; edge_st = 0;
    @(negedge clk); do_halt = 1'b1; m0 = mem_strb_s; r0 = reg_strb_s;
    @(negedge clk); do_halt = 1'b0;
    for (int c = 1; c <= 800; c++) begin
      @(negedge clk);
      if (sbus.mem_rd_en && first_rd_c < 0) first_rd_c = c;
      if (sbus.dump_valid && first_vld_c < 0) first_vld_c = c;
      if (done_s) begin n_done++; done_c = c; done_busy = busy_s; end
      if (rst_at_reg >= 0 && sbus.dump_valid && sbus.dump_is_reg && sbus.dump_index == 8'(rst_at_reg)) begin
        sbus.dump_ready = 1'b0; rst = 1'b1; rst_hit = 1; break;
      end
      case (mode)
        0: sbus.dump_ready = 1'b1;
        1: sbus.dump_ready = 1'($urandom_range(0, 1));
        default: begin
          if (sbus.dump_valid && !sbus.dump_is_reg && sbus.dump_index == 8'd3 && stall < 10) begin
            sbus.dump_ready = 1'b0; stall++;
            if (sbus.dump_data !== 16'd9) hold_bad++;
            if (sbus.mem_rd_en || sbus.reg_rd_en) stall_strobes++;
          end else sbus.dump_ready = 1'b1;
        end
      endcase
      if (edge_at >= 0) begin
        if (edge_st == 0 && sbus.dump_valid && n_acc == edge_at) begin do_halt = 1'b1; edge_st = 1; end
        else if (edge_st == 1) begin do_halt = 1'b0; edge_st = 2; end
      end
      if (sbus.dump_valid && sbus.dump_ready) begin
        w = word_t'({sbus.dump_is_reg, sbus.dump_index, sbus.dump_data});
        obs_q.push_back(w); n_acc++; last_acc_c = c;
      end
      if (done_c > 0 && c >= done_c + 4) break;
    end
    if (rst_hit) begin
      @(negedge clk);
      rst_vec = {busy_s, done_s, sbus.mem_rd_en, sbus.mem_rd_addr, sbus.reg_rd_en, sbus.reg_rd_idx,
                 sbus.dump_valid, sbus.dump_data, sbus.dump_is_reg, sbus.dump_index};
      rst = 1'b0;
      repeat (3) @(negedge clk);
      idle_after = !busy_s && !sbus.mem_rd_en && !done_s;
    end else begin
      if (done_c < 0) timed_out = 1;
      idle_after = !busy_s && !sbus.dump_valid;
    end
    stall_cnt = stall;
    rd_mem_n = mem_strb_s - m0;
    rd_reg_n = reg_strb_s - r0;
    sbus.dump_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; do_halt = 1'b1; do_halt_b = 1'b0; sbus.dump_ready = 1'b0; bbus.dump_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy_s, done_s, sbus.mem_rd_en, sbus.reg_rd_en, sbus.dump_valid, sbus.dump_data,
         sbus.dump_index, sbus.mem_rd_addr, sbus.reg_rd_idx, sbus.dump_is_reg} !== '0) begin
      fails++; $display("FAIL reset_outputs: some output nonzero during reset, want all 0");
    end
    do_halt = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy_s !== 1'b0 || sbus.mem_rd_en !== 1'b0) begin
      fails++; $display("FAIL reset_no_start: busy=%0b rd_en=%0b after reset with halt dropping, want 0 0", busy_s, sbus.mem_rd_en);
    end
  endtask

  task automatic test_basic;
    word_t o, e;
    int k;
    fill_small_exp();
    run_small(0, -1, -1);
    tests++; if (timed_out) begin fails++; $display("FAIL basic_timeout: no dump_done within budget"); end
    tests++; if (first_rd_c !== 1) begin fails++; $display("FAIL basic_rd_latency: got %0d, want 1", first_rd_c); end
    tests++; if (first_vld_c !== 3) begin fails++; $display("FAIL basic_vld_latency: got %0d, want 3", first_vld_c); end
    tests++; if (n_acc !== 32) begin fails++; $display("FAIL basic_count: got %0d words, want 32", n_acc); end
    k = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); tests++;
      if (o !== e) begin
        fails++; $display("FAIL basic_word%0d: got reg=%0d idx=%0d data=%0d, want reg=%0d idx=%0d data=%0d",
                          k, o.is_reg, o.idx, o.data, e.is_reg, e.idx, e.data);
      end
      k++;
    end
    tests++; if (n_done !== 1) begin fails++; $display("FAIL basic_done_count: got %0d, want 1", n_done); end
    tests++; if (done_c !== last_acc_c + 1) begin fails++; $display("FAIL basic_done_timing: done at %0d, want %0d", done_c, last_acc_c + 1); end
    tests++; if (done_busy !== 1'b0) begin fails++; $display("FAIL basic_done_busy: busy=%0b in done cycle, want 0", done_busy); end
    tests++; if (rd_mem_n !== 16 || rd_reg_n !== 16) begin fails++; $display("FAIL basic_strobes: mem=%0d reg=%0d, want 16 16", rd_mem_n, rd_reg_n); end
    tests++; if (!idle_after) begin fails++; $display("FAIL basic_idle: not idle after done, want idle"); end
  endtask

  task automatic test_backpressure;
    word_t o, e;
    int k;
    fill_small_exp();
    run_small(2, -1, -1);
    tests++; if (stall_cnt !== 10) begin fails++; $display("FAIL bp_stall_cycles: held %0d cycles, want 10", stall_cnt); end
    tests++; if (hold_bad !== 0) begin fails++; $display("FAIL bp_hold: %0d cycles with data!=9, want 0", hold_bad); end
    tests++; if (stall_strobes !== 0) begin fails++; $display("FAIL bp_strobes: %0d strobes during stall, want 0", stall_strobes); end
    tests++; if (n_acc !== 32 || n_done !== 1) begin fails++; $display("FAIL bp_count: words=%0d done=%0d, want 32 1", n_acc, n_done); end
    k = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); tests++;
      if (o !== e) begin
        fails++; $display("FAIL bp_word%0d: got reg=%0d idx=%0d data=%0d, want reg=%0d idx=%0d data=%0d",
                          k, o.is_reg, o.idx, o.data, e.is_reg, e.idx, e.data);
      end
      k++;
    end
    tests++; if (rd_mem_n !== 16 || rd_reg_n !== 16) begin fails++; $display("FAIL bp_total_strobes: mem=%0d reg=%0d, want 16 16", rd_mem_n, rd_reg_n); end
  endtask

  task automatic test_random_ready;
    word_t o, e;
    int k;
    fill_small_exp();
    run_small(1, -1, -1);
    tests++; if (n_acc !== 32 || n_done !== 1 || timed_out) begin
      fails++; $display("FAIL rnd_count: words=%0d done=%0d timeout=%0b, want 32 1 0", n_acc, n_done, timed_out);
    end
    k = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); tests++;
      if (o !== e) begin
        fails++; $display("FAIL rnd_word%0d: got reg=%0d idx=%0d data=%0d, want reg=%0d idx=%0d data=%0d",
                          k, o.is_reg, o.idx, o.data, e.is_reg, e.idx, e.data);
      end
      k++;
    end
    tests++; if (done_c !== last_acc_c + 1) begin fails++; $display("FAIL rnd_done_timing: done at %0d, want %0d", done_c, last_acc_c + 1); end
  endtask

  task automatic test_second_edge;
    word_t o, e;
    int k;
    fill_small_exp();
    run_small(0, 5, -1);
    tests++; if (n_acc !== 32 || n_done !== 1) begin fails++; $display("FAIL edge_count: words=%0d done=%0d, want 32 1", n_acc, n_done); end
    k = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); tests++;
      if (o !== e) begin
        fails++; $display("FAIL edge_word%0d: got reg=%0d idx=%0d data=%0d, want reg=%0d idx=%0d data=%0d",
                          k, o.is_reg, o.idx, o.data, e.is_reg, e.idx, e.data);
      end
      k++;
    end
    tests++; if (!idle_after) begin fails++; $display("FAIL edge_restart: dump restarted after ignored edge, want idle"); end
  endtask

  task automatic test_reset_mid_dump;
    word_t o, e;
    int k;
    fill_small_exp();
    run_small(0, -1, 4);
    tests++; if (!rst_hit) begin fails++; $display("FAIL rstmid_reach: register 4 never presented, want reached"); end
    tests++; if (rst_vec !== '0) begin fails++; $display("FAIL rstmid_outputs: got 0x%0h, want 0", rst_vec); end
    tests++; if (n_acc !== 20 || n_done !== 0) begin fails++; $display("FAIL rstmid_count: words=%0d done=%0d, want 20 0", n_acc, n_done); end
    tests++; if (!idle_after) begin fails++; $display("FAIL rstmid_idle: activity after abort, want idle"); end
    fill_small_exp();
    run_small(0, -1, -1);
    tests++; if (n_acc !== 32 || n_done !== 1) begin fails++; $display("FAIL restart_count: words=%0d done=%0d, want 32 1", n_acc, n_done); end
    k = 0;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); tests++;
      if (o !== e) begin
        fails++; $display("FAIL restart_word%0d: got reg=%0d idx=%0d data=%0d, want reg=%0d idx=%0d data=%0d",
                          k, o.is_reg, o.idx, o.data, e.is_reg, e.idx, e.data);
      end
      k++;
    end
  endtask

  task automatic test_big_mem;
    word_t o, e;
    int nacc, ndone, dc, last_mem;
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(word_t'({1'b0, 8'(i), 16'(i * 7 + 1)}));
    exp_q.push_back(word_t'({1'b1, 8'd0, REG_B0}));
    nacc = 0; ndone = 0; dc = -1; last_mem = -1;
    @(negedge clk); do_halt_b = 1'b1;
    @(negedge clk); do_halt_b = 1'b0;
    for (int c = 1; c <= 1500; c++) begin
      @(negedge clk);
      bbus.dump_ready = 1'b1;
      if (done_b) begin ndone++; dc = c; end
      if (bbus.dump_valid) begin
        o = word_t'({bbus.dump_is_reg, bbus.dump_index, bbus.dump_data});
        if (!o.is_reg) last_mem = int'(o.idx);
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL big_extra: unexpected word reg=%0d idx=%0d data=%0d", o.is_reg, o.idx, o.data);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            fails++; $display("FAIL big_word%0d: got reg=%0d idx=%0d data=%0d, want reg=%0d idx=%0d data=%0d",
                              nacc, o.is_reg, o.idx, o.data, e.is_reg, e.idx, e.data);
          end
        end
        nacc++;
      end
      if (dc > 0 && c >= dc + 4) break;
    end
    bbus.dump_ready = 1'b0;
    tests++; if (nacc !== 257) begin fails++; $display("FAIL big_count: got %0d words, want 257", nacc); end
    tests++; if (last_mem !== 255) begin fails++; $display("FAIL big_last_mem: got %0d, want 255", last_mem); end
    tests++; if (ndone !== 1) begin fails++; $display("FAIL big_done: got %0d pulses, want 1", ndone); end
    tests++; if (busy_b !== 1'b0) begin fails++; $display("FAIL big_idle: busy=%0b after done, want 0", busy_b); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_s[i] = (i < 16) ? 16'(i * 3) : 16'hEEEE;
      mem_b[i] = 16'(i * 7 + 1);
    end
    for (int i = 0; i < 16; i++) regs_s[i] = 16'd0;
    regs_s[7] = 16'd7;
    regs_s[10] = 16'd624;
    sbus.dump_ready = 1'b0;
    bbus.dump_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_random_ready();
    test_second_edge();
    test_reset_mid_dump();
    test_big_mem();
    tests++;
    if (strobe_viol !== 0) begin
      fails++; $display("FAIL strobe_rules: %0d cycles with illegal read strobes, want 0", strobe_viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1);
  end

endmodule
